// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset PC, NOP encoding and queue entry type
// for the instruction fetch unit.
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with single-cycle flush; head is read combinationally.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    // Extra pointer bit distinguishes full from empty.
    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues sequential instruction fetches, queues returned words for the
// decoder, and discards in-flight responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]   outstanding, drop_cnt, occupancy;
    logic [CW:0]     load;
    logic            empty, pop, push, accept;
    fetch_entry_t    head;

    assign inst_valid = !empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    // Reserve a queue slot for every request in flight so responses never overflow.
    assign load           = {1'b0, outstanding} + {1'b0, occupancy} - (CW+1)'(pop);
    assign imem_req_valid = !rst && !redirect_valid && load < (CW+1)'(DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_resp_valid && !redirect_valid && drop_cnt == '0;
    assign instruction    = empty ? NOP : head.inst;
    assign inst_pc        = empty ? RESET_PC : head.pc;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop),
        .push_data({imem_resp_data, resp_pc}),
        .head     (head),
        .empty    (empty),
        .count    (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
                resp_pc  <= align_pc(redirect_pc);
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (push)   resp_pc  <= resp_pc + 32'd4;
                if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end
endmodule
